// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and elaboration helpers for the convolution engine
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IMG = 3'd1,
        LOAD_FLT = 3'd2,
        COMPUTE  = 3'd3,
        OUTPUT   = 3'd4,
        FIN      = 3'd5
    } conv_state_e;

    function automatic int out_w(input int img_w, input int flt_w, input int stride);
        return (img_w - flt_w) / stride + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// rtl/conv_mac_lane.sv - one signed multiply-accumulate lane; clear with en loads the first product
module conv_mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] pixel_i,
    input  logic signed [DATA_W-1:0] weight_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign prod     = pixel_i * weight_i;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = en_i ? prod_ext : '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_layer_engine.sv
// rtl/conv_layer_engine.sv - single-layer valid-mode convolution engine, one MAC lane per filter
// Optional CONV_RELU_EN: negative channel results leave as zero.
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int IMG_W  = 16,
    parameter int FLT_W  = 4,
    parameter int NUM_CH = 4,
    parameter int STRIDE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     keep_flt,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*ACC_W-1:0]  out_data,
    output logic [15:0]              out_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int OUT_W     = out_w(IMG_W, FLT_W, STRIDE);
    localparam int IMG_PIX   = IMG_W * IMG_W;
    localparam int FLT_TAPS  = FLT_W * FLT_W;
    localparam int FLT_WORDS = NUM_CH * FLT_TAPS;
    localparam int IMG_AW    = idx_w(IMG_PIX);
    localparam int FLT_AW    = idx_w(FLT_WORDS);
    localparam int LD_W      = idx_w(((IMG_PIX > FLT_WORDS) ? IMG_PIX : FLT_WORDS) + 1);
    localparam int CW        = idx_w(IMG_W + 1);

    if ((IMG_W - FLT_W) % STRIDE != 0) begin : g_bad_stride
        $error("conv_layer_engine: (IMG_W-FLT_W) must be a multiple of STRIDE");
    end

    conv_state_e     state_q, state_d;
    logic            keep_q, keep_d;
    logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]   orow_q, orow_d, ocol_q, ocol_d;
    logic [CW-1:0]   tr_q, tr_d, tc_q, tc_d;
    logic [15:0]     idx_q, idx_d;

    logic signed [DATA_W-1:0] img_mem [IMG_PIX];
    logic signed [DATA_W-1:0] flt_mem [FLT_WORDS];

    logic beat, last_tap, last_pix, acc_clr, acc_en;
    int   pix_a;
    logic signed [DATA_W-1:0] pix_rd;

    assign in_ready  = (state_q == LOAD_IMG) || (state_q == LOAD_FLT);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign out_idx   = idx_q;

    assign beat     = in_valid && in_ready;
    assign last_tap = (tr_q == CW'(FLT_W-1)) && (tc_q == CW'(FLT_W-1));
    assign last_pix = (orow_q == CW'(OUT_W-1)) && (ocol_q == CW'(OUT_W-1));
    assign acc_en   = (state_q == COMPUTE);
    assign acc_clr  = acc_en && (tr_q == '0) && (tc_q == '0);

    always_comb begin
        pix_a  = (int'(orow_q) * STRIDE + int'(tr_q)) * IMG_W + int'(ocol_q) * STRIDE + int'(tc_q);
        pix_rd = img_mem[IMG_AW'(pix_a)];
    end

    always_ff @(posedge clk) begin
        if (!rst && beat) begin
            if (state_q == LOAD_IMG) begin
                img_mem[IMG_AW'(ld_cnt_q)] <= in_data;
            end else begin
                flt_mem[FLT_AW'(ld_cnt_q)] <= in_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        keep_d   = keep_q;
        ld_cnt_d = ld_cnt_q;
        orow_d   = orow_q;
        ocol_d   = ocol_q;
        tr_d     = tr_q;
        tc_d     = tc_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD_IMG;
                    keep_d   = keep_flt;
                    ld_cnt_d = '0;
                    orow_d   = '0;
                    ocol_d   = '0;
                    tr_d     = '0;
                    tc_d     = '0;
                    idx_d    = '0;
                end
            end
            LOAD_IMG: begin
                if (beat) begin
                    if (ld_cnt_q == LD_W'(IMG_PIX-1)) begin
                        ld_cnt_d = '0;
                        state_d  = keep_q ? COMPUTE : LOAD_FLT;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LD_W'(1);
                    end
                end
            end
            LOAD_FLT: begin
                if (beat) begin
                    if (ld_cnt_q == LD_W'(FLT_WORDS-1)) begin
                        ld_cnt_d = '0;
                        state_d  = COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LD_W'(1);
                    end
                end
            end
            COMPUTE: begin
                // taps walk row-major; wrapping both counters leaves them ready for the next window
                if (tc_q == CW'(FLT_W-1)) begin
                    tc_d = '0;
                    tr_d = last_tap ? '0 : tr_q + CW'(1);
                end else begin
                    tc_d = tc_q + CW'(1);
                end
                if (last_tap) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (last_pix) begin
                        state_d = FIN;
                    end else begin
                        state_d = COMPUTE;
                        idx_d   = idx_q + 16'd1;
                        if (ocol_q == CW'(OUT_W-1)) begin
                            ocol_d = '0;
                            orow_d = orow_q + CW'(1);
                        end else begin
                            ocol_d = ocol_q + CW'(1);
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            keep_q   <= 1'b0;
            ld_cnt_q <= '0;
            orow_q   <= '0;
            ocol_q   <= '0;
            tr_q     <= '0;
            tc_q     <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            keep_q   <= keep_d;
            ld_cnt_q <= ld_cnt_d;
            orow_q   <= orow_d;
            ocol_q   <= ocol_d;
            tr_q     <= tr_d;
            tc_q     <= tc_d;
            idx_q    <= idx_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic signed [DATA_W-1:0] wt;
        logic signed [ACC_W-1:0]  acc;

        assign wt = flt_mem[FLT_AW'(c * FLT_TAPS + int'(tr_q) * FLT_W + int'(tc_q))];

        conv_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk_i    (clk),
            .rst_i    (rst),
            .clear_i  (acc_clr),
            .en_i     (acc_en),
            .pixel_i  (pix_rd),
            .weight_i (wt),
            .acc_o    (acc)
        );

`ifdef CONV_RELU_EN
        assign out_data[c*ACC_W +: ACC_W] = acc[ACC_W-1] ? '0 : acc;
`else
        assign out_data[c*ACC_W +: ACC_W] = acc;
`endif
    end

endmodule

// File: tb/tb_conv_layer_engine.sv
// tb/tb_conv_layer_engine.sv - self-checking bench for conv_layer_engine
`timescale 1ns/1ps
module tb_conv_layer_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int IMG_W  = 16;
    localparam int FLT_W  = 4;
    localparam int NUM_CH = 4;
    localparam int STRIDE = 1;
    localparam int OUT_W  = (IMG_W - FLT_W) / STRIDE + 1;
    localparam int NPIX   = OUT_W * OUT_W;
    localparam int IMG_N  = IMG_W * IMG_W;
    localparam int TAPS   = FLT_W * FLT_W;
    localparam int LOAD_N = IMG_N + NUM_CH * TAPS;

    logic clk = 1'b0;
    logic rst, start, keep_flt, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [DATA_W-1:0]       in_data;
    logic [NUM_CH*ACC_W-1:0] out_data;
    logic [15:0]             out_idx;

    always #5 clk = ~clk;

    conv_layer_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .IMG_W(IMG_W),
        .FLT_W(FLT_W), .NUM_CH(NUM_CH), .STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .keep_flt(keep_flt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int img [IMG_N];
    int flt [NUM_CH][TAPS];
    int expv [NPIX][NUM_CH];
    logic [ACC_W-1:0] got   [NPIX][NUM_CH];
    logic [ACC_W-1:0] saved [NPIX][NUM_CH];
    int got_idx [NPIX];
    int got_cyc [NPIX];

    int  beats, last_beat_cyc, n_out, done_cnt, stall_viol, first_valid_cyc;
    bit  load_timeout, out_timeout, idle_after;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; keep_flt = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // reference: plain nested-sum valid convolution, optional ReLU
    task automatic compute_model();
        for (int r = 0; r < OUT_W; r++)
            for (int c = 0; c < OUT_W; c++)
                for (int k = 0; k < NUM_CH; k++) begin
                    int s = 0;
                    for (int fr = 0; fr < FLT_W; fr++)
                        for (int fc = 0; fc < FLT_W; fc++)
                            s += img[(r*STRIDE+fr)*IMG_W + c*STRIDE+fc] * flt[k][fr*FLT_W+fc];
`ifdef CONV_RELU_EN
                    if (s < 0) s = 0;
`endif
                    expv[r*OUT_W+c][k] = s;
                end
    endtask

    task automatic start_run(input bit keep);
        start = 1'b1; keep_flt = keep;
        step();
        start = 1'b0; keep_flt = 1'b0;
    endtask

    task automatic load_stream();
        int v;
        beats = 0; load_timeout = 1'b1; last_beat_cyc = cyc;
        for (int t = 0; t < 5000; t++) begin
            if (!in_ready) begin
                load_timeout = 1'b0;
                break;
            end
            if (beats < IMG_N) v = img[beats];
            else if (beats < LOAD_N) v = flt[(beats-IMG_N)/TAPS][(beats-IMG_N)%TAPS];
            else v = 0;
            in_valid = ($urandom_range(3) != 0);
            in_data  = DATA_W'(v);
            if (in_valid) last_beat_cyc = cyc;
            step();
            if (in_valid) beats++;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect_out(input int mode);
        logic [NUM_CH*ACC_W-1:0] held_d;
        logic [15:0] held_i;
        bit held_v, hold_done;
        int hold;
        held_v = 0; hold_done = 0; hold = 0; n_out = 0; done_cnt = 0; stall_viol = 0;
        first_valid_cyc = -1; out_timeout = 1'b1; idle_after = 1'b0;
        held_d = '0; held_i = '0;
        for (int t = 0; t < 20000; t++) begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mode == 0) out_ready = 1'b1;
            else if (out_valid && !hold_done) begin
                out_ready = 1'b0;
                hold++;
                hold_done = (hold >= 50);
            end else out_ready = 1'($urandom_range(1));
            if (held_v && (!out_valid || out_data !== held_d || out_idx !== held_i)) stall_viol++;
            held_v = 0;
            if (out_valid && out_ready) begin
                if (n_out < NPIX) begin
                    for (int c = 0; c < NUM_CH; c++) got[n_out][c] = out_data[c*ACC_W +: ACC_W];
                    got_idx[n_out] = int'(out_idx);
                    got_cyc[n_out] = cyc;
                end
                n_out++;
            end else if (out_valid) begin
                held_v = 1; held_d = out_data; held_i = out_idx;
            end
            if (done) begin
                done_cnt++;
                out_timeout = 1'b0;
                step();
                if (done) done_cnt++;
                idle_after = !busy;
                break;
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: busy/in_ready/out_valid/done=%b want 0000", {busy, in_ready, out_valid, done});
        end
        checks++; if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        checks++; if (out_idx !== 16'd0) begin
            errors++; $display("FAIL reset_out_idx: got %0d want 0", out_idx);
        end
    endtask

    task automatic test_ones();
        int bad_d, bad_i, bad_t;
        for (int i = 0; i < IMG_N; i++) img[i] = 1;
        for (int k = 0; k < NUM_CH; k++) for (int t = 0; t < TAPS; t++) flt[k][t] = 1;
        start_run(1'b0);
        load_stream();
        collect_out(0);
        checks++; if (load_timeout || beats != LOAD_N) begin
            errors++; $display("FAIL ones_load_beats: got %0d (timeout %0d) want %0d", beats, load_timeout, LOAD_N);
        end
        checks++; if (out_timeout || n_out != NPIX) begin
            errors++; $display("FAIL ones_count: got %0d (timeout %0d) want %0d", n_out, out_timeout, NPIX);
        end
        checks++; if (done_cnt != 1 || !idle_after) begin
            errors++; $display("FAIL ones_done: pulses %0d idle_after %0d want 1 1", done_cnt, idle_after);
        end
        checks++; if (first_valid_cyc - last_beat_cyc != TAPS + 1) begin
            errors++; $display("FAIL ones_latency: got %0d want %0d", first_valid_cyc - last_beat_cyc, TAPS + 1);
        end
        bad_d = 0; bad_i = 0; bad_t = 0;
        for (int i = 0; i < NPIX && i < n_out; i++) begin
            if (got_idx[i] != i) bad_i++;
            for (int k = 0; k < NUM_CH; k++) if (got[i][k] !== 32'd16) bad_d++;
            if (i > 0 && got_cyc[i] - got_cyc[i-1] != TAPS + 1) bad_t++;
        end
        checks++; if (bad_i != 0) begin
            errors++; $display("FAIL ones_idx: %0d out-of-order indices want 0", bad_i);
        end
        checks++; if (bad_d != 0) begin
            errors++; $display("FAIL ones_data: %0d channel values differ from 16, want 0", bad_d);
        end
        checks++; if (bad_t != 0) begin
            errors++; $display("FAIL ones_throughput: %0d gaps differ from %0d cycles, want 0", bad_t, TAPS + 1);
        end
    endtask

    task automatic test_pattern();
        int bad, r, c, e;
        for (int rr = 0; rr < IMG_W; rr++) for (int cc = 0; cc < IMG_W; cc++) img[rr*IMG_W+cc] = (rr + cc) & 7;
        for (int k = 0; k < NUM_CH; k++) for (int t = 0; t < TAPS; t++) flt[k][t] = (t == 0) ? k + 1 : 0;
        start_run(1'b0);
        load_stream();
        collect_out(0);
        checks++; if (out_timeout || n_out != NPIX) begin
            errors++; $display("FAIL pattern_count: got %0d want %0d", n_out, NPIX);
        end
        bad = 0;
        for (int i = 0; i < NPIX && i < n_out; i++) begin
            r = i / OUT_W; c = i % OUT_W;
            for (int k = 0; k < NUM_CH; k++) begin
                e = ((r + c) & 7) * (k + 1);
                if (got[i][k] !== 32'(e)) begin
                    if (bad == 0) $display("FAIL pattern_data: idx %0d ch %0d got %0d want %0d", i, k, got[i][k], e);
                    bad++;
                end
            end
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL pattern_total: %0d wrong channel values, want 0", bad);
        end
    endtask

    task automatic test_stall();
        int bad, bad_i;
        for (int i = 0; i < IMG_N; i++) img[i] = int'($urandom_range(255)) - 128;
        for (int k = 0; k < NUM_CH; k++) for (int t = 0; t < TAPS; t++) flt[k][t] = int'($urandom_range(255)) - 128;
        compute_model();
        start_run(1'b0);
        load_stream();
        collect_out(1);
        checks++; if (out_timeout || n_out != NPIX || done_cnt != 1) begin
            errors++; $display("FAIL stall_count: got %0d outputs %0d done want %0d 1", n_out, done_cnt, NPIX);
        end
        checks++; if (stall_viol != 0) begin
            errors++; $display("FAIL stall_stable: %0d changes while stalled, want 0", stall_viol);
        end
        bad = 0; bad_i = 0;
        for (int i = 0; i < NPIX && i < n_out; i++) begin
            if (got_idx[i] != i) bad_i++;
            for (int k = 0; k < NUM_CH; k++) begin
                saved[i][k] = got[i][k];
                if (got[i][k] !== 32'(expv[i][k])) bad++;
            end
        end
        checks++; if (bad_i != 0) begin
            errors++; $display("FAIL stall_idx: %0d lost/duplicated indices, want 0", bad_i);
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL stall_data: %0d channel values differ from model, want 0", bad);
        end
    endtask

    // runs the cycle after the previous done, so it also covers back-to-back start
    task automatic test_keep_flt();
        int bad;
        for (int k = 0; k < NUM_CH; k++) for (int t = 0; t < TAPS; t++) flt[k][t] = int'($urandom_range(255)) - 128;
        start_run(1'b1);
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL back_to_back_start: in_ready %b want 1", in_ready);
        end
        load_stream();
        collect_out(0);
        checks++; if (load_timeout || beats != IMG_N) begin
            errors++; $display("FAIL keep_beats: got %0d want %0d", beats, IMG_N);
        end
        bad = 0;
        for (int i = 0; i < NPIX && i < n_out; i++)
            for (int k = 0; k < NUM_CH; k++) if (got[i][k] !== saved[i][k]) bad++;
        checks++; if (bad != 0 || n_out != NPIX) begin
            errors++; $display("FAIL keep_data: %0d differences over %0d outputs, want 0 over %0d", bad, n_out, NPIX);
        end
    endtask

    task automatic test_negative();
        int bad;
        logic [ACC_W-1:0] e;
`ifdef CONV_RELU_EN
        e = 32'd0;
`else
        e = 32'hFFFF_FFF0;
`endif
        for (int i = 0; i < IMG_N; i++) img[i] = 1;
        for (int k = 0; k < NUM_CH; k++) for (int t = 0; t < TAPS; t++) flt[k][t] = -1;
        start_run(1'b0);
        load_stream();
        collect_out(0);
        bad = 0;
        for (int i = 0; i < NPIX && i < n_out; i++)
            for (int k = 0; k < NUM_CH; k++) if (got[i][k] !== e) bad++;
        checks++; if (bad != 0 || n_out != NPIX) begin
            errors++; $display("FAIL negative_data: %0d values differ from %h over %0d outputs", bad, e, n_out);
        end
    endtask

    task automatic test_reset_mid();
        int bad, extra_done;
        for (int i = 0; i < IMG_N; i++) img[i] = int'($urandom_range(255)) - 128;
        for (int k = 0; k < NUM_CH; k++) for (int t = 0; t < TAPS; t++) flt[k][t] = int'($urandom_range(255)) - 128;
        compute_model();
        start_run(1'b0);
        load_stream();
        out_ready = 1'b1;
        for (int t = 0; t < 100 && cyc < last_beat_cyc + 21; t++) step();
        checks++; if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before: busy %b want 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        checks++; if ({busy, out_valid, done, in_ready} !== 4'b0000) begin
            errors++; $display("FAIL abort_state: busy/out_valid/done/in_ready=%b want 0000", {busy, out_valid, done, in_ready});
        end
        checks++; if (out_data !== '0 || out_idx !== 16'd0) begin
            errors++; $display("FAIL abort_outputs: data %h idx %0d want 0 0", out_data, out_idx);
        end
        extra_done = 0;
        for (int t = 0; t < 10; t++) begin
            if (done || busy) extra_done++;
            step();
        end
        checks++; if (extra_done != 0) begin
            errors++; $display("FAIL abort_no_done: %0d cycles with done/busy after abort, want 0", extra_done);
        end
        start_run(1'b0);
        load_stream();
        collect_out(0);
        bad = 0;
        for (int i = 0; i < NPIX && i < n_out; i++)
            for (int k = 0; k < NUM_CH; k++) if (got[i][k] !== 32'(expv[i][k])) bad++;
        checks++; if (bad != 0 || n_out != NPIX || done_cnt != 1) begin
            errors++; $display("FAIL abort_rerun: %0d wrong values, %0d outputs, %0d done want 0 %0d 1", bad, n_out, done_cnt, NPIX);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ones();
        test_pattern();
        test_stall();
        test_keep_flt();
        test_negative();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_engine.md
Name: conv_layer_engine

Overview:
Parametrised single-layer convolution engine; successor to the fixed 4-channel, two-layer conv datapath. Streams one square image and NUM_CH filters into internal buffers, then computes the valid-mode convolution with one MAC lane per filter channel. Outputs leave one pixel per handshake, all channels side by side. Instances chain layer-to-layer in the top-level CNN datapath.

Parameters:
DATA_W, 8, pixel and weight width (signed two's complement)
ACC_W, 32, accumulator/output width per channel (signed)
IMG_W, 16, image side length in pixels
FLT_W, 4, filter side length in taps
NUM_CH, 4, number of filters = output channels
STRIDE, 1, step between windows; elaboration error if (IMG_W-FLT_W)%STRIDE != 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a layer run; sampled only in IDLE
keep_flt  in  1  sampled with start; 1 = skip filter load and reuse stored weights
in_valid  in  1  load-stream data valid
in_ready  out  1  load-stream ready
in_data  in  DATA_W  pixel or weight
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_data  out  NUM_CH*ACC_W  channel c at bits [c*ACC_W +: ACC_W]
out_idx  out  16  row-major output pixel index
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- OUT_W = (IMG_W-FLT_W)/STRIDE+1; run emits OUT_W*OUT_W pixels (defaults: 13x13 = 169).
- Reset: state IDLE; in_ready, out_valid, busy, done = 0; out_data, out_idx = 0; counters 0. Buffer contents not cleared. Reset mid-operation aborts immediately to IDLE with no done pulse.
- FSM IDLE -> LOAD_IMG -> LOAD_FLT -> COMPUTE -> OUTPUT -> (COMPUTE | FIN) -> IDLE.
- IDLE: start=1 -> LOAD_IMG next cycle. start outside IDLE ignored.
- LOAD_IMG: in_ready=1. Each in_valid&in_ready beat writes the next pixel, row-major. After IMG_W*IMG_W beats -> LOAD_FLT, or COMPUTE if keep_flt was 1.
- LOAD_FLT: in_ready=1. NUM_CH*FLT_W*FLT_W beats, channel-major then row-major. After the last beat -> COMPUTE. in_ready=0 in every other state.
- COMPUTE: accumulators cleared on entry. Exactly FLT_W*FLT_W cycles; each cycle, every lane adds sign-extended pixel*weight for one tap in row-major order. Window origin = (orow*STRIDE, ocol*STRIDE). Wrap-around overflow in ACC_W, no saturation. -> OUTPUT.
- OUTPUT: out_valid=1; out_data and out_idx stable until out_ready. On handshake: last pixel -> FIN, else advance index, next COMPUTE.
- Latency: first out_valid FLT_W*FLT_W+1 cycles after the last load beat. Throughput is one pixel per FLT_W*FLT_W+1 cycles with out_ready tied high.
- FIN: done=1 for one cycle -> IDLE. Back-to-back start is accepted the cycle after done.
- keep_flt=1 immediately after reset with no prior load uses whatever weights are stored; this is legal, result unspecified.

Optional Feature:
CONV_RELU_EN. Defined: each channel result below 0 is output as 0 (ReLU on out_data). Undefined: raw signed accumulator is output.

Decomposition:
- Package conv_pkg: state enum typedef (IDLE, LOAD_IMG, LOAD_FLT, COMPUTE, OUTPUT, FIN); constant function out_w(img_w, flt_w, stride); index-width helper (clog2-based).
- Sub-module conv_mac_lane (DATA_W, ACC_W): clear, en, pixel, weight -> acc; NUM_CH copies in a generate loop.

Test Plan:
- All-ones image, all-ones filters, defaults -> 169 outputs, every channel = 16, out_idx 0..168, one done pulse.
- Image pixel(r,c) = (r+c)&7; channel k has tap (0,0) = k+1, rest 0 -> channel k of out_idx r*13+c = ((r+c)&7)*(k+1).
- out_ready toggled randomly and held low 50 cycles -> out_data/out_idx stable while stalled; no pixel lost or duplicated.
- Second run with keep_flt=1 -> only 256 load beats accepted; results identical to first run.
- Ones image, all weights = -1 -> 0xFFFFFFF0 per channel without CONV_RELU_EN; 0 with it.
- rst asserted at 20th COMPUTE cycle -> next cycle IDLE, out_valid=0, busy=0, no done; a fresh run then completes correctly.
